// File: rtl/alu_sys_pkg.sv
// ----------------------------------------------------------------------------
// alu_sys_pkg
//   Shared definitions for the ALU command controller: FSM state encoding,
//   command bytes that open a frame, and the ALU function codes.
// ----------------------------------------------------------------------------
package alu_sys_pkg;

    localparam int DATA_WIDTH   = 8;
    localparam int RESULT_WIDTH = 2 * DATA_WIDTH;

    // Frame-opening command bytes
    localparam logic [7:0] CMD_ALU_OPER  = 8'hCC;  // A, B, FUN follow
    localparam logic [7:0] CMD_ALU_NOPER = 8'hDD;  // only FUN follows

    // ALU function codes
    localparam logic [3:0] FUN_ADD   = 4'h0;
    localparam logic [3:0] FUN_SUB   = 4'h1;
    localparam logic [3:0] FUN_MUL   = 4'h2;
    localparam logic [3:0] FUN_DIV   = 4'h3;
    localparam logic [3:0] FUN_AND   = 4'h4;
    localparam logic [3:0] FUN_OR    = 4'h5;
    localparam logic [3:0] FUN_NAND  = 4'h6;
    localparam logic [3:0] FUN_NOR   = 4'h7;
    localparam logic [3:0] FUN_XOR   = 4'h8;
    localparam logic [3:0] FUN_XNOR  = 4'h9;
    localparam logic [3:0] FUN_CMPEQ = 4'hA;
    localparam logic [3:0] FUN_CMPGT = 4'hB;
    localparam logic [3:0] FUN_CMPLT = 4'hC;
    localparam logic [3:0] FUN_SHR   = 4'hD;
    localparam logic [3:0] FUN_SHL   = 4'hE;

    // Ten states do not fit in three bits, so the encoding is four bits wide.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_GET_A    = 4'd1,
        ST_GET_B    = 4'd2,
        ST_GET_FUN  = 4'd3,
        ST_EXEC     = 4'd4,
        ST_WAIT_RES = 4'd5,
        ST_SEND_LO  = 4'd6,
        ST_GUARD_LO = 4'd7,
        ST_SEND_HI  = 4'd8,
        ST_GUARD_HI = 4'd9
    } state_e;

endpackage : alu_sys_pkg

// File: rtl/alu_sys_ctrl.sv
// ----------------------------------------------------------------------------
// alu_sys_ctrl
//   Command-side controller for an ALU. Parses command frames from a UART RX
//   byte stream, loads operands/function into the ALU, pulses its enable,
//   captures the 16-bit result and sends it to the UART TX low byte first.
//
// Ports
//   i_clk            system clock
//   i_rst            asynchronous active-high reset
//   i_rx_data[7:0]   received byte
//   i_rx_valid       1-cycle strobe, i_rx_data valid
//   o_alu_a[7:0]     operand A (registered)
//   o_alu_b[7:0]     operand B (registered)
//   o_alu_fun[3:0]   function code (registered)
//   o_alu_en         1-cycle ALU enable pulse
//   i_alu_out[15:0]  ALU result
//   i_alu_out_valid  ALU result valid
//   o_tx_data[7:0]   byte to transmit (registered)
//   o_tx_valid       1-cycle transmit request
//   i_tx_busy        transmitter busy
//   o_ctrl_busy      high in every state except IDLE
//   o_state          current FSM state (debug/observability)
//
// Handshakes
//   RX: i_rx_valid is a strobe with no back-pressure; a byte arriving while
//       the FSM is not collecting a frame is dropped, o_ctrl_busy warns the
//       sender. TX: a byte is offered only when i_tx_busy is low and is then
//       presented with o_tx_valid for exactly one cycle; a guard cycle
//       follows so the transmitter has time to raise i_tx_busy.
// ----------------------------------------------------------------------------
module alu_sys_ctrl
    import alu_sys_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [DATA_WIDTH-1:0]   i_rx_data,
    input  logic                    i_rx_valid,
    output logic [DATA_WIDTH-1:0]   o_alu_a,
    output logic [DATA_WIDTH-1:0]   o_alu_b,
    output logic [3:0]              o_alu_fun,
    output logic                    o_alu_en,
    input  logic [RESULT_WIDTH-1:0] i_alu_out,
    input  logic                    i_alu_out_valid,
    output logic [DATA_WIDTH-1:0]   o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_busy,
    output logic                    o_ctrl_busy,
    output state_e                  o_state
);

    state_e                  r_state;
    logic [DATA_WIDTH-1:0]   r_alu_a;
    logic [DATA_WIDTH-1:0]   r_alu_b;
    logic [3:0]              r_alu_fun;
    logic                    r_alu_en;
    logic [RESULT_WIDTH-1:0] r_res;
    logic [DATA_WIDTH-1:0]   r_tx_data;
    logic                    r_tx_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_fun  <= '0;
            r_alu_en   <= 1'b0;
            r_res      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            r_alu_en   <= 1'b0;
            r_tx_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (i_rx_valid) begin
                        if (i_rx_data == CMD_ALU_OPER) begin
                            r_state <= ST_GET_A;
                        end else if (i_rx_data == CMD_ALU_NOPER) begin
                            r_state <= ST_GET_FUN;
                        end
                    end
                end

                ST_GET_A: begin
                    if (i_rx_valid) begin
                        r_alu_a <= i_rx_data;
                        r_state <= ST_GET_B;
                    end
                end

                ST_GET_B: begin
                    if (i_rx_valid) begin
                        r_alu_b <= i_rx_data;
                        r_state <= ST_GET_FUN;
                    end
                end

                ST_GET_FUN: begin
                    if (i_rx_valid) begin
                        r_alu_fun <= i_rx_data[3:0];
                        // Enable is raised on entry so it is high for the
                        // whole EXEC cycle, one cycle after the last byte.
                        r_alu_en  <= 1'b1;
                        r_state   <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    r_state <= ST_WAIT_RES;
                end

                ST_WAIT_RES: begin
                    if (i_alu_out_valid) begin
                        r_res   <= i_alu_out;
                        r_state <= ST_SEND_LO;
                    end
                end

                ST_SEND_LO: begin
                    // While the transmitter is busy, TX data is left untouched.
                    if (!i_tx_busy) begin
                        r_tx_data  <= r_res[7:0];
                        r_tx_valid <= 1'b1;
                        r_state    <= ST_GUARD_LO;
                    end
                end

                ST_GUARD_LO: begin
                    r_state <= ST_SEND_HI;
                end

                ST_SEND_HI: begin
                    if (!i_tx_busy) begin
                        r_tx_data  <= r_res[15:8];
                        r_tx_valid <= 1'b1;
                        r_state    <= ST_GUARD_HI;
                    end
                end

                ST_GUARD_HI: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;
    assign o_alu_fun   = r_alu_fun;
    assign o_alu_en    = r_alu_en;
    assign o_tx_data   = r_tx_data;
    assign o_tx_valid  = r_tx_valid;
    // Decoded from the state register, so it is glitch-free and drops to 0
    // as soon as reset forces IDLE.
    assign o_ctrl_busy = (r_state != ST_IDLE);
    assign o_state     = r_state;

endmodule : alu_sys_ctrl

// File: tb/tb_alu_sys_ctrl.sv
module tb_alu_sys_ctrl;
  import alu_sys_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_fun;
  logic        alu_en;
  logic [15:0] alu_out;
  logic        alu_out_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_busy;
  logic        ctrl_busy;
  state_e      st;

  alu_sys_ctrl dut (
    .i_clk(clk), .i_rst(rst),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_fun(alu_fun), .o_alu_en(alu_en),
    .i_alu_out(alu_out), .i_alu_out_valid(alu_out_valid),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_busy(tx_busy),
    .o_ctrl_busy(ctrl_busy), .o_state(st)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_tx_cyc = -100;
  int en_count = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_e;
  logic [7:0] m_a = 8'h00;
  logic [7:0] m_b = 8'h00;
  logic [3:0] m_fun = 4'h0;

  bit force_busy = 1'b0;
  bit model_busy = 1'b0;
  int tx_len = 1;
  logic        stub_valid = 1'b0;
  logic [15:0] stub_out = 16'h0;
  logic [15:0] stub_res;
  logic        spur_valid = 1'b0;

  assign tx_busy       = force_busy | model_busy;
  assign alu_out_valid = stub_valid | spur_valid;
  assign alu_out       = spur_valid ? 16'hBEEF : stub_out;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU behaviour from the function-code table.
  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      FUN_ADD:   return {8'h00, a} + {8'h00, b};
      FUN_SUB:   return {8'h00, a} - {8'h00, b};
      FUN_MUL:   return {8'h00, a} * {8'h00, b};
      FUN_DIV:   return (b == 8'h00) ? 16'h0000 : {8'h00, a / b};
      FUN_AND:   return {8'h00, a & b};
      FUN_OR:    return {8'h00, a | b};
      FUN_NAND:  return {8'h00, ~(a & b)};
      FUN_NOR:   return {8'h00, ~(a | b)};
      FUN_XOR:   return {8'h00, a ^ b};
      FUN_XNOR:  return {8'h00, ~(a ^ b)};
      FUN_CMPEQ: return (a == b) ? 16'd1 : 16'd0;
      FUN_CMPGT: return (a > b) ? 16'd1 : 16'd0;
      FUN_CMPLT: return (a < b) ? 16'd1 : 16'd0;
      FUN_SHR:   return {9'h000, a[7:1]};
      FUN_SHL:   return {7'h00, a, 1'b0};
      default:   return 16'h0000;
    endcase
  endfunction

  // ---------------- scoreboard: TX bytes and ALU loads ----------------
  always @(negedge clk) begin
    if (tx_valid) begin
      last_tx_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected actual=%0h expected=none", tx_data);
      end else begin
        tx_e = exp_q.pop_front();
        if (tx_data !== tx_e) begin
          errors++;
          $display("FAIL tx_byte actual=%0h expected=%0h", tx_data, tx_e);
        end
      end
    end
    if (alu_en) begin
      en_count++;
      check("alu_a_at_en", 32'(alu_a), 32'(m_a));
      check("alu_b_at_en", 32'(alu_b), 32'(m_b));
      check("alu_fun_at_en", 32'(alu_fun), 32'(m_fun));
    end
  end

  // ---------------- ALU stub: result one cycle after EN ----------------
  always begin
    @(negedge clk);
    if (alu_en) begin
      stub_res = alu_ref(alu_a, alu_b, alu_fun);
      @(posedge clk); #1;
      stub_out = stub_res;
      stub_valid = 1'b1;
      @(posedge clk); #1;
      stub_valid = 1'b0;
      stub_out = 16'($urandom);
    end
  end

  // ---------------- UART TX stub: busy for 1..4 cycles per byte ----------------
  always begin
    @(negedge clk);
    if (tx_valid) begin
      tx_len = $urandom_range(1, 4);
      @(posedge clk); #1;
      model_busy = 1'b1;
      repeat (tx_len) @(posedge clk);
      #1;
      model_busy = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rx_put(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_valid = 1'b1;
  endtask

  task automatic rx_idle();
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (ctrl_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (ctrl_busy) begin
      check("frame_done_timeout", 32'(ctrl_busy), 32'd0);
    end else begin
      // IDLE follows the single GUARD_HI cycle that carried the high byte.
      check("busy_fall_after_guard_hi", 32'(cyc - last_tx_cyc), 32'd1);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    end
    n = 0;
    while (tx_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic push_frame(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] f, input logic [7:0] ea, input logic [7:0] eb,
                            input logic [3:0] ef, input logic [7:0] elo, input logic [7:0] ehi);
    m_a = ea;
    m_b = eb;
    m_fun = ef;
    exp_q.push_back(elo);
    exp_q.push_back(ehi);
    rx_put(cmd);
    if (cmd == CMD_ALU_OPER) begin
      rx_put(a);
      rx_put(b);
    end
    rx_put(f);
    rx_idle();
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] f, input logic [7:0] ea, input logic [7:0] eb,
                            input logic [3:0] ef, input logic [7:0] elo, input logic [7:0] ehi);
    int en_before;
    en_before = en_count;
    push_frame(cmd, a, b, f, ea, eb, ef, elo, ehi);
    @(negedge clk);
    check("ctrl_busy_in_frame", 32'(ctrl_busy), 32'd1);
    wait_idle();
    check("en_pulses_per_frame", 32'(en_count - en_before), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    check({tag, "_alu_fun"}, 32'(alu_fun), 32'd0);
    check({tag, "_alu_en"}, 32'(alu_en), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_ctrl_busy"}, 32'(ctrl_busy), 32'd0);
    check({tag, "_state"}, 32'(st), 32'(ST_IDLE));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] cmd, a, b, f, ea, eb;
    logic [3:0] ef;
    logic [7:0] elo, ehi;
  } vec_t;

  vec_t tbl[8];

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int en_before;
    logic [7:0] cmd, a, b, f, ea, eb, junk;
    logic [15:0] r;

    tbl[0] = '{CMD_ALU_NOPER, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00}; // DD before any CC
    tbl[1] = '{CMD_ALU_OPER,  8'h05, 8'h03, 8'h00, 8'h05, 8'h03, 4'h0, 8'h08, 8'h00}; // add
    tbl[2] = '{CMD_ALU_OPER,  8'hFF, 8'hFF, 8'h02, 8'hFF, 8'hFF, 4'h2, 8'h01, 8'hFE}; // multiply
    tbl[3] = '{CMD_ALU_NOPER, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 4'h1, 8'h00, 8'h00}; // reuse, sub
    tbl[4] = '{CMD_ALU_OPER,  8'h3C, 8'h0F, 8'hF4, 8'h3C, 8'h0F, 4'h4, 8'h0C, 8'h00}; // and, upper nibble ignored
    tbl[5] = '{CMD_ALU_OPER,  8'h10, 8'h03, 8'h03, 8'h10, 8'h03, 4'h3, 8'h05, 8'h00}; // div
    tbl[6] = '{CMD_ALU_NOPER, 8'h00, 8'h00, 8'hA5, 8'h10, 8'h03, 4'h5, 8'h13, 8'h00}; // reuse, or
    tbl[7] = '{CMD_ALU_OPER,  8'h80, 8'h02, 8'h0E, 8'h80, 8'h02, 4'hE, 8'h00, 8'h01}; // shl

    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].cmd, tbl[i].a, tbl[i].b, tbl[i].f,
                 tbl[i].ea, tbl[i].eb, tbl[i].ef, tbl[i].elo, tbl[i].ehi);
    end

    // Latency: EN one cycle after last byte, first TX_VALID four cycles after.
    push_frame(CMD_ALU_OPER, 8'h05, 8'h03, 8'h00, 8'h05, 8'h03, 4'h0, 8'h08, 8'h00);
    @(negedge clk);
    check("lat_en_high", 32'(alu_en), 32'd1);
    @(negedge clk);
    check("lat_en_single", 32'(alu_en), 32'd0);
    check("lat_wait_res", 32'(st), 32'(ST_WAIT_RES));
    @(negedge clk);
    check("lat_send_lo_novalid", 32'(tx_valid), 32'd0);
    @(negedge clk);
    check("lat_first_tx_valid", 32'(tx_valid), 32'd1);
    wait_idle();

    // TX back-pressure for 20 cycles in SEND_LO; TX_DATA holds the last high byte 00.
    force_busy = 1'b1;
    push_frame(CMD_ALU_OPER, 8'h12, 8'h34, 8'h00, 8'h12, 8'h34, 4'h0, 8'h46, 8'h00);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_state", 32'(st), 32'(ST_SEND_LO));
      check("bp_tx_valid", 32'(tx_valid), 32'd0);
      check("bp_tx_data_stable", 32'(tx_data), 32'h00);
    end
    @(posedge clk); #1;
    force_busy = 1'b0;
    @(negedge clk);
    check("bp_release_same_cycle", 32'(tx_valid), 32'd0);
    @(negedge clk);
    check("bp_release_next_cycle", 32'(tx_valid), 32'd1);
    check("bp_release_data", 32'(tx_data), 32'h46);
    wait_idle();

    // Junk byte in IDLE and stray ALU valid in IDLE.
    rx_put(8'h7A);
    rx_idle();
    @(negedge clk);
    check("junk_state", 32'(st), 32'(ST_IDLE));
    check("junk_busy", 32'(ctrl_busy), 32'd0);
    @(posedge clk); #1;
    spur_valid = 1'b1;
    @(posedge clk); #1;
    spur_valid = 1'b0;
    @(negedge clk);
    check("stray_alu_valid_state", 32'(st), 32'(ST_IDLE));

    // Bytes arriving in EXEC/WAIT_RES/SEND_LO are dropped.
    en_before = en_count;
    push_frame(CMD_ALU_OPER, 8'h07, 8'h06, 8'h02, 8'h07, 8'h06, 4'h2, 8'h2A, 8'h00);
    rx_put(CMD_ALU_OPER);
    rx_put(8'h55);
    rx_idle();
    wait_idle();
    check("drop_en_pulses", 32'(en_count - en_before), 32'd1);
    check("drop_alu_a_kept", 32'(alu_a), 32'h07);
    check("drop_alu_b_kept", 32'(alu_b), 32'h06);
    check("drop_state_idle", 32'(st), 32'(ST_IDLE));

    // Reset in GET_B
    rx_put(CMD_ALU_OPER);
    rx_put(8'h11);
    rx_idle();
    check("pre_rst_state_get_b", 32'(st), 32'(ST_GET_B));
    check("pre_rst_alu_a", 32'(alu_a), 32'h11);
    rst = 1'b1;
    #1;
    check_all_zero("rst_get_b");
    @(posedge clk); #1;
    rst = 1'b0;
    m_a = 8'h00;
    m_b = 8'h00;
    send_frame(CMD_ALU_NOPER, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00);
    send_frame(CMD_ALU_OPER, 8'h09, 8'h04, 8'h01, 8'h09, 8'h04, 4'h1, 8'h05, 8'h00);

    // Reset in SEND_HI: only the low byte goes out, nothing afterwards.
    m_a = 8'h21;
    m_b = 8'h43;
    m_fun = 4'h0;
    exp_q.push_back(8'h64);
    rx_put(CMD_ALU_OPER);
    rx_put(8'h21);
    rx_put(8'h43);
    rx_put(8'h00);
    rx_idle();
    n = 0;
    while (st != ST_GUARD_LO && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("reach_guard_lo", 32'(st), 32'(ST_GUARD_LO));
    force_busy = 1'b1;
    @(negedge clk);
    check("pre_rst_state_send_hi", 32'(st), 32'(ST_SEND_HI));
    rst = 1'b1;
    #1;
    check_all_zero("rst_send_hi");
    @(posedge clk); #1;
    rst = 1'b0;
    force_busy = 1'b0;
    m_a = 8'h00;
    m_b = 8'h00;
    repeat (10) @(negedge clk);
    check("rst_send_hi_no_resend", 32'(exp_q.size()), 32'd0);
    send_frame(CMD_ALU_OPER, 8'h02, 8'h03, 8'h02, 8'h02, 8'h03, 4'h2, 8'h06, 8'h00);

    // Randomized frames against the reference model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom);
        if (junk == CMD_ALU_OPER || junk == CMD_ALU_NOPER) junk = junk ^ 8'h01;
        rx_put(junk);
        rx_idle();
      end
      cmd = ($urandom_range(0, 3) == 0) ? CMD_ALU_NOPER : CMD_ALU_OPER;
      a = 8'($urandom);
      b = 8'($urandom);
      f = 8'($urandom);
      ea = (cmd == CMD_ALU_OPER) ? a : m_a;
      eb = (cmd == CMD_ALU_OPER) ? b : m_b;
      r = alu_ref(ea, eb, f[3:0]);
      send_frame(cmd, a, b, f, ea, eb, f[3:0], r[7:0], r[15:8]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu_sys_ctrl
